// File: rtl/dmem_access_unit.sv
// -----------------------------------------------------------------------------
// dmem_access_unit
//
// MEM-stage load/store unit. It sits between the pipelined core and a
// valid/ready data memory whose latency varies. The unit captures the core's
// access, issues one word-aligned request with byte enables, waits for read
// data when the access is a load, and returns sign- or zero-extended data.
// The pipeline is held in stall until the access finishes.
//
// Build option:
//   DMEM_MISALIGN_TRAP_EN  When defined, a misaligned half or word access
//                          never reaches memory. It completes on the next
//                          cycle with bus_err=1 and cpu_rdata=0. When not
//                          defined, the address is forced to natural
//                          alignment and the access proceeds.
//
// Parameters:
//   TIMEOUT_CYC  Cycles allowed in REQ+WAIT before the access is aborted with
//                bus_err. The counter is 8 bits, so the legal range is 1..255.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   cpu_req      MEM-stage load/store; the core holds it stable while stall=1
//   cpu_we       1 = store, 0 = load
//   cpu_addr     byte address
//   cpu_wdata    store data, right-justified
//   cpu_dmtype   000 word, 001 half, 010 half-u, 011 byte, 100 byte-u
//   cpu_rdata    extended load data; holds until the next completion
//   stall        freezes the upstream pipeline registers
//   done         one-cycle pulse when an access finishes
//   bus_err      abort flag (timeout or misalignment); holds until next done
//   mem_valid    request valid
//   mem_ready    request accepted when mem_valid & mem_ready
//   mem_we       write request
//   mem_addr     word-aligned request address
//   mem_be       byte enables
//   mem_wdata    store data placed in its byte lanes
//   mem_rdata    full read word
//   mem_rvalid   read data valid, single cycle
// -----------------------------------------------------------------------------
module dmem_access_unit #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [2:0]  cpu_dmtype,
  output logic [31:0] cpu_rdata,
  output logic        stall,
  output logic        done,
  output logic        bus_err,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rvalid
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_e;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  // The abort happens when the counter reaches this value, so REQ+WAIT
  // lasts exactly TIMEOUT_CYC cycles.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

  // Undefined encodings (101..111) fall into the word case.
  function automatic logic [1:0] acc_size(input logic [2:0] dmtype);
    case (dmtype)
      3'b001, 3'b010: acc_size = SZ_H;
      3'b011, 3'b100: acc_size = SZ_B;
      default:        acc_size = SZ_W;
    endcase
  endfunction

  // Byte lane of the access. Halves and words ignore the address bits below
  // their natural alignment.
  function automatic logic [1:0] lane_off(input logic [1:0] a, input logic [1:0] sz);
    case (sz)
      SZ_B:    lane_off = a;
      SZ_H:    lane_off = {a[1], 1'b0};
      default: lane_off = 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] byte_en(input logic [1:0] sz, input logic [1:0] off);
    case (sz)
      SZ_B:    byte_en = 4'b0001 << off;
      SZ_H:    byte_en = 4'b0011 << off;
      default: byte_en = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_lanes(input logic [31:0] wdata,
                                              input logic [1:0]  sz,
                                              input logic [1:0]  off);
    case (sz)
      SZ_B:    store_lanes = {24'h0, wdata[7:0]}  << {off, 3'b000};
      SZ_H:    store_lanes = {16'h0, wdata[15:0]} << {off, 3'b000};
      default: store_lanes = wdata;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] rdata,
                                              input logic [2:0]  dmtype,
                                              input logic [1:0]  off);
    logic [31:0] sh;
    sh = rdata >> {off, 3'b000};
    case (dmtype)
      3'b001:  load_extend = {{16{sh[15]}}, sh[15:0]};
      3'b010:  load_extend = {16'h0, sh[15:0]};
      3'b011:  load_extend = {{24{sh[7]}}, sh[7:0]};
      3'b100:  load_extend = {24'h0, sh[7:0]};
      default: load_extend = rdata;
    endcase
  endfunction

`ifdef DMEM_MISALIGN_TRAP_EN
  function automatic logic misaligned(input logic [1:0] a, input logic [1:0] sz);
    misaligned = ((sz == SZ_H) && a[0]) || ((sz == SZ_W) && (a != 2'b00));
  endfunction
`endif

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  dmtype_q, dmtype_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [1:0]  cur_sz;
  logic [1:0]  cur_off;
  logic        timed_out;

  assign cur_sz    = acc_size(dmtype_q);
  assign cur_off   = lane_off(addr_q[1:0], cur_sz);
  assign timed_out = (cnt_q >= TO_LAST);

  // State and access registers. Everything, including the returned data,
  // clears on reset so that all outputs read zero immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      dmtype_q <= '0;
      cnt_q    <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      dmtype_q <= dmtype_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    we_d     = we_q;
    wdata_d  = wdata_q;
    dmtype_d = dmtype_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    err_d    = err_q;

    case (state_q)
      S_IDLE: begin
        if (cpu_req) begin
          addr_d   = cpu_addr;
          we_d     = cpu_we;
          wdata_d  = cpu_wdata;
          dmtype_d = cpu_dmtype;
`ifdef DMEM_MISALIGN_TRAP_EN
          if (misaligned(cpu_addr[1:0], acc_size(cpu_dmtype))) begin
            state_d = S_DONE;
            rdata_d = '0;
            err_d   = 1'b1;
          end else begin
            state_d = S_REQ;
            cnt_d   = '0;
          end
`else
          state_d = S_REQ;
          cnt_d   = '0;
`endif
        end
      end

      S_REQ: begin
        if (mem_ready) begin
          if (we_q) begin
            state_d = S_DONE;
            rdata_d = '0;
            err_d   = 1'b0;
          end else begin
            // The counter keeps running into WAIT so the budget covers
            // request and response together.
            state_d = S_WAIT;
            cnt_d   = cnt_q + 8'd1;
          end
        end else if (timed_out) begin
          state_d = S_DONE;
          rdata_d = '0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      S_WAIT: begin
        if (mem_rvalid) begin
          state_d = S_DONE;
          rdata_d = load_extend(mem_rdata, dmtype_q, cur_off);
          err_d   = 1'b0;
        end else if (timed_out) begin
          state_d = S_DONE;
          rdata_d = '0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      // A request still visible here belongs to the instruction that is
      // just leaving MEM, so it must not start another access.
      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs
  always_comb begin
    stall     = 1'b0;
    done      = 1'b0;
    mem_valid = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_be    = '0;
    mem_wdata = '0;

    case (state_q)
      S_IDLE: stall = cpu_req;
      S_REQ: begin
        stall     = 1'b1;
        mem_valid = 1'b1;
        mem_we    = we_q;
        mem_addr  = {addr_q[31:2], 2'b00};
        mem_be    = byte_en(cur_sz, cur_off);
        mem_wdata = we_q ? store_lanes(wdata_q, cur_sz, cur_off) : 32'h0;
      end
      S_WAIT: stall = 1'b1;
      S_DONE: done  = 1'b1;
      default: ;
    endcase
  end

  assign cpu_rdata = rdata_q;
  assign bus_err   = err_q;

endmodule

// File: tb/tb_dmem_access_unit.sv
module tb_dmem_access_unit;

  localparam int TO = 12;

  logic        clk;
  logic        rst;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [2:0]  cpu_dmtype;
  logic [31:0] cpu_rdata;
  logic        stall;
  logic        done;
  logic        bus_err;
  logic        mem_valid;
  logic        mem_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_rvalid;

  int checks = 0;
  int errors = 0;

  dmem_access_unit #(.TIMEOUT_CYC(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_dmtype (cpu_dmtype),
    .cpu_rdata  (cpu_rdata),
    .stall      (stall),
    .done       (done),
    .bus_err    (bus_err),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_rvalid (mem_rvalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  dmt;
    logic [31:0] rd;     // word returned by memory
    int          lat;    // cycles from handshake to rvalid
    logic [3:0]  be;
    logic [31:0] maddr;
    logic [31:0] mwdata;
    logic [31:0] rdata;  // expected cpu_rdata (loads)
    int          dcyc;   // cycle of done counted from cpu_req rising
  } vec_t;

  localparam int NV = 13;
  vec_t vecs[NV];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b", nm, act, exp);
    end
  endtask

  task automatic check_all_zero(input string pfx);
    chk ({pfx, "_cpu_rdata"}, cpu_rdata, 32'h0);
    chk1({pfx, "_stall"},     stall,     1'b0);
    chk1({pfx, "_done"},      done,      1'b0);
    chk1({pfx, "_bus_err"},   bus_err,   1'b0);
    chk1({pfx, "_mem_valid"}, mem_valid, 1'b0);
    chk1({pfx, "_mem_we"},    mem_we,    1'b0);
    chk ({pfx, "_mem_addr"},  mem_addr,  32'h0);
    chk ({pfx, "_mem_be"},    32'(mem_be), 32'h0);
    chk ({pfx, "_mem_wdata"}, mem_wdata, 32'h0);
  endtask

  // One complete access: memory accepts at once, read data after v.lat.
  task automatic run_vec(input string nm, input vec_t v);
    bit got_done;
    bit hs_seen;
    int hs_cyc;
    int dcyc;
    @(negedge clk);
    cpu_req    = 1'b1;
    cpu_we     = v.we;
    cpu_addr   = v.addr;
    cpu_wdata  = v.wdata;
    cpu_dmtype = v.dmt;
    mem_ready  = 1'b1;
    #1;
    chk1({nm, "_stall_req"}, stall, 1'b1);
    got_done = 0;
    hs_seen  = 0;
    hs_cyc   = 0;
    dcyc     = 0;
    for (int c = 1; c <= 40 && !got_done; c++) begin
      @(negedge clk);
      mem_rvalid = 1'b0;
      mem_rdata  = 32'hBAD0BAD0;
      if (done) begin
        got_done = 1;
        dcyc     = c;
        cpu_req  = 1'b0;
      end else begin
        if (mem_valid && mem_ready && !hs_seen) begin
          hs_seen = 1;
          hs_cyc  = c;
          chk ({nm, "_mem_addr"}, mem_addr, v.maddr);
          chk ({nm, "_mem_be"},   32'(mem_be), 32'(v.be));
          chk1({nm, "_mem_we"},   mem_we, v.we);
          if (v.we) chk({nm, "_mem_wdata"}, mem_wdata, v.mwdata);
        end
        if (hs_seen && !v.we && c == hs_cyc + v.lat) begin
          mem_rvalid = 1'b1;
          mem_rdata  = v.rd;
        end
      end
    end
    chk1({nm, "_done_seen"}, got_done, 1'b1);
    chk ({nm, "_done_cycle"}, 32'(dcyc), 32'(v.dcyc));
    chk1({nm, "_bus_err"}, bus_err, 1'b0);
    chk1({nm, "_stall_done"}, stall, 1'b0);
    if (!v.we) chk({nm, "_cpu_rdata"}, cpu_rdata, v.rdata);
    @(negedge clk);
    chk1({nm, "_done_pulse"}, done, 1'b0);
    chk1({nm, "_valid_after"}, mem_valid, 1'b0);
    if (!v.we) chk({nm, "_rdata_hold"}, cpu_rdata, v.rdata);
  endtask

  initial begin
    bit got;
    int dcyc;
    logic [8:0] dv;

    vecs[0]  = '{1'b1, 32'h104, 32'hDEADBEEF, 3'b000, 32'h0,        0, 4'b1111, 32'h104, 32'hDEADBEEF, 32'h0,        2};
    vecs[1]  = '{1'b1, 32'h103, 32'h000000A5, 3'b011, 32'h0,        0, 4'b1000, 32'h100, 32'hA5000000, 32'h0,        2};
    vecs[2]  = '{1'b1, 32'h102, 32'h0000BEEF, 3'b001, 32'h0,        0, 4'b1100, 32'h100, 32'hBEEF0000, 32'h0,        2};
    vecs[3]  = '{1'b1, 32'h100, 32'hFFFFFF5A, 3'b100, 32'h0,        0, 4'b0001, 32'h100, 32'h0000005A, 32'h0,        2};
    vecs[4]  = '{1'b1, 32'h201, 32'h00000077, 3'b011, 32'h0,        0, 4'b0010, 32'h200, 32'h00007700, 32'h0,        2};
    vecs[5]  = '{1'b0, 32'h102, 32'h0,        3'b011, 32'h12F45678, 3, 4'b0100, 32'h100, 32'h0,        32'hFFFFFFF4, 5};
    vecs[6]  = '{1'b0, 32'h102, 32'h0,        3'b100, 32'h12F45678, 1, 4'b0100, 32'h100, 32'h0,        32'h000000F4, 3};
    vecs[7]  = '{1'b0, 32'h102, 32'h0,        3'b010, 32'h12F45678, 2, 4'b1100, 32'h100, 32'h0,        32'h000012F4, 4};
    vecs[8]  = '{1'b0, 32'h100, 32'h0,        3'b001, 32'h12F48678, 1, 4'b0011, 32'h100, 32'h0,        32'hFFFF8678, 3};
    vecs[9]  = '{1'b0, 32'h102, 32'h0,        3'b001, 32'hF2345678, 1, 4'b1100, 32'h100, 32'h0,        32'hFFFFF234, 3};
    vecs[10] = '{1'b0, 32'h108, 32'h0,        3'b000, 32'hCAFEF00D, 1, 4'b1111, 32'h108, 32'h0,        32'hCAFEF00D, 3};
    vecs[11] = '{1'b0, 32'h101, 32'h0,        3'b100, 32'h12F45678, 2, 4'b0010, 32'h100, 32'h0,        32'h00000056, 4};
    vecs[12] = '{1'b0, 32'h10C, 32'h0,        3'b111, 32'h89ABCDEF, 1, 4'b1111, 32'h10C, 32'h0,        32'h89ABCDEF, 3};

    rst        = 1'b0;
    cpu_req    = 1'b0;
    cpu_we     = 1'b0;
    cpu_addr   = 32'h0;
    cpu_wdata  = 32'h0;
    cpu_dmtype = 3'b000;
    mem_ready  = 1'b0;
    mem_rdata  = 32'h0;
    mem_rvalid = 1'b0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rst = 1'b1;
    @(negedge clk);

    // Table of single accesses
    for (int i = 0; i < NV; i++) run_vec($sformatf("v%0d", i), vecs[i]);

    // Load that is never accepted: abort after TO cycles
    @(negedge clk);
    cpu_req    = 1'b1;
    cpu_we     = 1'b0;
    cpu_addr   = 32'h400;
    cpu_dmtype = 3'b000;
    mem_ready  = 1'b0;
    got  = 0;
    dcyc = 0;
    for (int c = 1; c <= TO + 10 && !got; c++) begin
      @(negedge clk);
      if (done) begin
        got  = 1;
        dcyc = c;
      end else if (c == 1 || c == TO) begin
        chk1($sformatf("to_valid_c%0d", c), mem_valid, 1'b1);
      end
    end
    chk1("to_done_seen", got, 1'b1);
    chk ("to_done_cycle", 32'(dcyc), 32'(TO + 1));
    chk1("to_bus_err", bus_err, 1'b1);
    chk ("to_cpu_rdata", cpu_rdata, 32'h0);
    chk1("to_mem_valid", mem_valid, 1'b0);
    cpu_req = 1'b0;
    @(negedge clk);
    chk1("to_done_pulse", done, 1'b0);
    chk1("to_err_hold", bus_err, 1'b1);
    chk1("to_valid_after", mem_valid, 1'b0);

    // The next good access clears bus_err
    run_vec("after_to", vecs[0]);

    // Back-to-back sw then lw with cpu_req held high through DONE
    dv = '0;
    @(negedge clk);
    cpu_req    = 1'b1;
    cpu_we     = 1'b1;
    cpu_addr   = 32'h200;
    cpu_wdata  = 32'h11223344;
    cpu_dmtype = 3'b000;
    mem_ready  = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      mem_rvalid = 1'b0;
      mem_rdata  = 32'hBAD0BAD0;
      dv[c] = done;
      if (c == 2) begin
        chk1("b2b_stall_done", stall, 1'b0);
        cpu_we   = 1'b0;
        cpu_addr = 32'h204;
      end
      if (c == 3) begin
        chk1("b2b_idle_valid", mem_valid, 1'b0);
        chk1("b2b_idle_stall", stall, 1'b1);
      end
      if (c == 4) begin
        chk1("b2b_lw_valid", mem_valid, 1'b1);
        chk ("b2b_lw_addr", mem_addr, 32'h204);
        chk1("b2b_lw_we", mem_we, 1'b0);
      end
      if (c == 5) begin
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h55667788;
      end
      if (c == 6) begin
        chk("b2b_lw_rdata", cpu_rdata, 32'h55667788);
        cpu_req = 1'b0;
      end
    end
    chk("b2b_done_pattern", 32'(dv), 32'h044);

    // Reset while waiting for read data
    @(negedge clk);
    cpu_req    = 1'b1;
    cpu_we     = 1'b0;
    cpu_addr   = 32'h300;
    cpu_dmtype = 3'b000;
    mem_ready  = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk1("rw_wait_valid", mem_valid, 1'b0);
    chk1("rw_wait_stall", stall, 1'b1);
    @(negedge clk);
    rst     = 1'b0;
    cpu_req = 1'b0;
    #1;
    check_all_zero("rw_reset");
    @(negedge clk);
    rst        = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hFFFFFFFF;
    @(negedge clk);
    mem_rvalid = 1'b0;
    chk1("rw_late_done", done, 1'b0);
    chk ("rw_late_rdata", cpu_rdata, 32'h0);
    chk1("rw_late_valid", mem_valid, 1'b0);
    @(negedge clk);
    chk1("rw_late_done2", done, 1'b0);
    chk ("rw_late_rdata2", cpu_rdata, 32'h0);

    // Misaligned accesses
    run_vec("pre_mis", vecs[10]);
`ifdef DMEM_MISALIGN_TRAP_EN
    @(negedge clk);
    cpu_req    = 1'b1;
    cpu_we     = 1'b0;
    cpu_addr   = 32'h106;
    cpu_dmtype = 3'b000;
    mem_ready  = 1'b1;
    #1;
    chk1("mis_valid_c0", mem_valid, 1'b0);
    @(negedge clk);
    chk1("mis_done", done, 1'b1);
    chk1("mis_bus_err", bus_err, 1'b1);
    chk ("mis_rdata", cpu_rdata, 32'h0);
    chk1("mis_valid_c1", mem_valid, 1'b0);
    cpu_req = 1'b0;
    @(negedge clk);
    chk1("mis_done_pulse", done, 1'b0);
    chk1("mis_valid_c2", mem_valid, 1'b0);
`else
    run_vec("mis_lw", '{1'b0, 32'h106, 32'h0, 3'b000, 32'hA1B2C3D4, 1, 4'b1111, 32'h104, 32'h0, 32'hA1B2C3D4, 3});
    run_vec("mis_sh", '{1'b1, 32'h103, 32'h00001234, 3'b001, 32'h0, 0, 4'b1100, 32'h100, 32'h12340000, 32'h0, 2});
    run_vec("mis_lh", '{1'b0, 32'h101, 32'h0, 3'b001, 32'h80FF7F00, 2, 4'b0011, 32'h100, 32'h0, 32'h00007F00, 4});
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
